// File: rtl/cpu_commit.sv
// Commit stage (4a) of the stack-machine pipeline: owns the operand stack,
// applies pops/pushes from execute, and resolves branches into redirect/kill.
module cpu_commit #(
    parameter int DEPTH       = 64,
    parameter int KILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        alu__cond_3a,
    input  logic [31:0] alu__out_3a,
    input  logic [1:0]  c__branch_3a,
    input  logic [2:0]  c__to_push_3a,
    input  logic [10:0] st__to_pop_3a,
    input  logic [34:0] r0_3a,
    input  logic [34:0] r1_3a,
    output logic        kill_4a,
    output logic        redirect_4a,
    output logic [31:0] redirect_pc_4a,
    output logic [10:0] st__sp_4a,
    output logic [34:0] st__top_0_4a,
    output logic [34:0] st__top_1_4a,
    output logic        st__fault_4a
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] DEPTH_SP  = 11'(DEPTH);
    localparam logic [2:0]  KILL_INIT = 3'(KILL_CYCLES);

    logic [34:0]   mem [DEPTH];
    logic [2:0]    kill_cnt;
    logic          squash;
    logic          taken;
    logic [10:0]   sp_d;
    logic          fault_d;
    logic          blocked;
    logic [2:0]    we;
    logic [AW-1:0] wa [3];
    logic [34:0]   wd [3];
    logic [34:0]   push_val [3];
    logic [AW-1:0] rd0_addr;
    logic [AW-1:0] rd1_addr;

    assign squash = (kill_cnt != 3'd0);

    assign taken = (c__branch_3a == 2'd1)
                 | ((c__branch_3a == 2'd2) &  alu__cond_3a)
                 | ((c__branch_3a == 2'd3) & ~alu__cond_3a);

    // Index matches the push-mask bit: bit2=r1, bit1=r0, bit0=ALU result.
    assign push_val[0] = {3'b000, alu__out_3a};
    assign push_val[1] = r0_3a;
    assign push_val[2] = r1_3a;

    // Pop first, then push r1, r0, ALU so the ALU result ends on top.
    always_comb begin
        sp_d    = st__sp_4a;
        fault_d = st__fault_4a;
        blocked = 1'b0;
        we      = 3'b000;
        wa      = '{default: '0};
        wd      = '{default: '0};
        if (!squash) begin
            if (st__to_pop_3a > st__sp_4a) begin
                sp_d    = 11'd0;
                fault_d = 1'b1;
            end else begin
                sp_d = st__sp_4a - st__to_pop_3a;
            end
            for (int i = 2; i >= 0; i--) begin
                if (c__to_push_3a[i]) begin
                    if (blocked || sp_d == DEPTH_SP) begin
                        blocked = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        we[i] = 1'b1;
                        wa[i] = AW'(sp_d);
                        wd[i] = push_val[i];
                        sp_d  = sp_d + 11'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            st__sp_4a      <= 11'd0;
            st__fault_4a   <= 1'b0;
            kill_cnt       <= 3'd0;
            kill_4a        <= 1'b0;
            redirect_4a    <= 1'b0;
            redirect_pc_4a <= 32'd0;
        end else begin
            st__sp_4a    <= sp_d;
            st__fault_4a <= fault_d;
            if (squash) begin
                kill_cnt    <= kill_cnt - 3'd1;
                kill_4a     <= (kill_cnt != 3'd1);
                redirect_4a <= 1'b0;
            end else if (taken) begin
                kill_cnt       <= KILL_INIT;
                kill_4a        <= (KILL_INIT != 3'd0);
                redirect_4a    <= 1'b1;
                redirect_pc_4a <= alu__out_3a;
            end else begin
                redirect_4a <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i]) mem[wa[i]] <= wd[i];
        end
    end

    assign rd0_addr = AW'(st__sp_4a - 11'd1);
    assign rd1_addr = AW'(st__sp_4a - 11'd2);

    always_comb begin
        st__top_0_4a = 35'd0;
        st__top_1_4a = 35'd0;
        if (st__sp_4a >= 11'd1) st__top_0_4a = mem[rd0_addr];
        if (st__sp_4a >= 11'd2) st__top_1_4a = mem[rd1_addr];
    end

endmodule
